// File: rtl/ltsm_sb_pkg.sv
// Shared LTSM sideband definitions: SB message codes, arbiter state encoding,
// requester source IDs and the grant-pick helper.
package ltsm_sb_pkg;

    localparam int SB_MSG_W = 4;

    localparam logic [SB_MSG_W-1:0] SB_MSG_TRAINERROR_ENTRY_REQ  = 4'd15;
    localparam logic [SB_MSG_W-1:0] SB_MSG_TRAINERROR_ENTRY_RESP = 4'd14;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_ACCEPT = 2'd2,
        ARB_DONE   = 2'd3
    } arb_state_e;

    localparam logic SRC_TX = 1'b0;
    localparam logic SRC_RX = 1'b1;

    // On a tie the requester that was not served last wins; passing SRC_RX as
    // the last-served source yields fixed TX-over-RX priority.
    function automatic logic arb_pick(input logic tx_req, input logic rx_req,
                                      input logic last_src);
        if (tx_req && rx_req)
            return (last_src == SRC_TX) ? SRC_RX : SRC_TX;
        return tx_req ? SRC_TX : SRC_RX;
    endfunction

endpackage

// File: rtl/sb_busy_edge_det.sv
// Registers the SB serializer busy flag and flags its rising/falling edges
// against the previous-cycle value.
module sb_busy_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic busy_i,
    output logic rise_o,
    output logic fall_o
);

    logic busy_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) busy_q <= 1'b0;
        else          busy_q <= busy_i;
    end

    assign rise_o = busy_i & ~busy_q;
    assign fall_o = ~busy_i & busy_q;

endmodule

// File: rtl/ltsm_sb_msg_arbiter.sv
// Single owner of the SB message-transmit port, shared by the TX and RX halves of an
// LTSM substate. Define LTSM_SB_ARB_RR_EN for round-robin instead of fixed TX>RX priority.
module ltsm_sb_msg_arbiter
    import ltsm_sb_pkg::*;
#(
    parameter int SB_MSG_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_tx_req,
    input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
    input  logic                    i_rx_req,
    input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
    input  logic                    i_sb_busy,
    output logic                    o_sb_valid,
    output logic [SB_MSG_WIDTH-1:0] o_sb_msg,
    output logic                    o_sb_src,
    output logic                    o_tx_done,
    output logic                    o_rx_done
);

    arb_state_e              state_q, state_d;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic                    src_q, src_d;
    logic                    valid_q, tx_done_q, rx_done_q;
    logic                    hold_q;
    logic                    busy_rise, busy_fall;
    logic                    last_src, grant_src;

    sb_busy_edge_det u_busy_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .busy_i  (i_sb_busy),
        .rise_o  (busy_rise),
        .fall_o  (busy_fall)
    );

`ifdef LTSM_SB_ARB_RR_EN
    logic last_q;

    // Pointer moves only on a completed send; an abort leaves it untouched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                          last_q <= SRC_RX;
        else if (i_en && state_q == ARB_DONE)  last_q <= src_q;
    end

    assign last_src = last_q;
`else
    assign last_src = SRC_RX;
`endif

    assign grant_src = arb_pick(i_tx_req, i_rx_req, last_src);

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        src_d   = src_q;
        if (!i_en) begin
            state_d = ARB_IDLE;
            msg_d   = '0;
            src_d   = SRC_TX;
        end else begin
            case (state_q)
                // hold_q masks the cycle right after DONE, while the served
                // requester may still be holding its request.
                ARB_IDLE: begin
                    if ((i_tx_req || i_rx_req) && !i_sb_busy && !hold_q) begin
                        state_d = ARB_ISSUE;
                        src_d   = grant_src;
                        msg_d   = (grant_src == SRC_RX) ? i_rx_msg : i_tx_msg;
                    end
                end
                ARB_ISSUE:  if (busy_rise) state_d = ARB_ACCEPT;
                ARB_ACCEPT: if (busy_fall) state_d = ARB_DONE;
                ARB_DONE:   state_d = ARB_IDLE;
                default:    state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ARB_IDLE;
            msg_q     <= '0;
            src_q     <= SRC_TX;
            valid_q   <= 1'b0;
            tx_done_q <= 1'b0;
            rx_done_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            src_q     <= src_d;
            valid_q   <= (state_d == ARB_ISSUE);
            tx_done_q <= (state_d == ARB_DONE) && (src_d == SRC_TX);
            rx_done_q <= (state_d == ARB_DONE) && (src_d == SRC_RX);
            hold_q    <= (state_q == ARB_DONE);
        end
    end

    assign o_sb_valid = valid_q;
    assign o_sb_msg   = msg_q;
    assign o_sb_src   = src_q;
    assign o_tx_done  = tx_done_q;
    assign o_rx_done  = rx_done_q;

endmodule
